// File: rtl/clk_div_pkg.sv
//==============================================================================
// Module      : clk_div_pkg
// Description : Shared divisor type and period helpers for the clock divider.
// Revision    : 1.0 - initial multi-channel release
//==============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int DIV_W = 32;

    typedef logic [DIV_W-1:0] div_t;

    // A divisor of zero behaves exactly like a divisor of one.
    function automatic div_t eff_div(input div_t d);
        return (d == '0) ? div_t'(1) : d;
    endfunction

    // Number of high cycles per period; odd periods get the extra cycle high.
    function automatic div_t hi_len(input div_t d);
        logic [DIV_W:0] w_sum;
        w_sum = {1'b0, eff_div(d)} + {{DIV_W{1'b0}}, 1'b1};
        return w_sum[DIV_W:1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
//==============================================================================
// Module      : clk_div_ch
// Description : One divider channel: counter, active/pending divisor, outputs.
// Revision    : 1.0 - initial multi-channel release
//==============================================================================
`default_nettype none

module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = clk_div_pkg::DIV_W,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_valid,
    input  logic             i_en,
    input  logic             i_sync,
    output logic             o_div_clk,
    output logic             o_div_tick,
    output logic             o_div_pend
);

    localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DIV_RST);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cur;
    logic [DIV_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_active;
    logic             r_clk;
    logic             r_tick;

    logic [DIV_W-1:0] w_eff;
    logic [DIV_W-1:0] w_hi;
    logic [DIV_W-1:0] w_next_div;
    logic [DIV_W-1:0] w_cnt_inc;
    logic             w_boundary;
    logic             w_restart;

    // DIV_W must not exceed the package divisor width.
    always_comb begin
        w_eff      = DIV_W'(eff_div(div_t'(r_cur)));
        w_hi       = DIV_W'(hi_len(div_t'(r_cur)));
        w_boundary = r_active && (r_cnt == (w_eff - c_one));
        w_restart  = !r_active || i_sync;
        w_next_div = i_div_valid ? i_div : r_pend_val;
        w_cnt_inc  = r_cnt + c_one;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cur      <= c_div_rst;
            r_pend_val <= c_div_rst;
            r_pend     <= 1'b0;
            r_active   <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!i_en) begin
            // Idle channel: outputs drop at once and divisor changes land directly.
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
            r_pend   <= 1'b0;
            if (i_div_valid) begin
                r_cur      <= i_div;
                r_pend_val <= i_div;
            end else if (r_pend) begin
                r_cur <= r_pend_val;
            end
        end else if (w_restart || w_boundary) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_clk    <= 1'b1;
            r_tick   <= 1'b1;
            r_pend   <= 1'b0;
            if (i_div_valid || r_pend) begin
                r_cur <= w_next_div;
            end
            if (i_div_valid) begin
                r_pend_val <= i_div;
            end
        end else begin
            r_cnt  <= w_cnt_inc;
            r_clk  <= (w_cnt_inc < w_hi);
            r_tick <= 1'b0;
            if (i_div_valid) begin
                r_pend_val <= i_div;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_div_clk  = r_clk;
    assign o_div_tick = r_tick;
    assign o_div_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_divider_mc.sv
//==============================================================================
// Module      : clk_divider_mc
// Description : Multi-channel glitch-free programmable clock divider with sync.
// Revision    : 1.0 - initial multi-channel release
//==============================================================================
`default_nettype none

module clk_divider_mc
    import clk_div_pkg::*;
#(
    parameter int CH      = 4,
    parameter int DIV_W   = clk_div_pkg::DIV_W,
    parameter int DIV_RST = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*DIV_W-1:0] div,
    input  logic [CH-1:0]       div_valid,
    input  logic [CH-1:0]       div_clk_en,
    input  logic                sync,
    output logic [CH-1:0]       div_clk,
    output logic [CH-1:0]       div_tick,
    output logic [CH-1:0]       div_pend
);

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_div       (div[gi*DIV_W +: DIV_W]),
            .i_div_valid (div_valid[gi]),
            .i_en        (div_clk_en[gi]),
            .i_sync      (sync),
            .o_div_clk   (div_clk[gi]),
            .o_div_tick  (div_tick[gi]),
            .o_div_pend  (div_pend[gi])
        );
    end

endmodule

`default_nettype wire
